// File: rtl/dac_feed_pkg.sv
// Shared types and constants for the DAC feed path.
// Contents:
//   state_e      - feeder sequencing states
//   DacWDef      - default DAC word width
//   SAT_MAX/MIN  - saturation limits for the default DAC word width
package dac_feed_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam int unsigned DacWDef = 16;

  localparam logic [DacWDef-1:0] SAT_MAX = {1'b0, {(DacWDef-1){1'b1}}};
  localparam logic [DacWDef-1:0] SAT_MIN = {1'b1, {(DacWDef-1){1'b0}}};

endpackage

// File: rtl/dac_fifo_feeder_if.sv
// Stream-in / FIFO-write bundle for the DAC feeder.
// Signals:
//   s_valid, s_data              - filter output sample (no backpressure)
//   fifo_full                    - DAC FIFO full flag
//   dacfifo_write, dacfifo_wdata - FIFO write strobe and data
// Modports:
//   master - the feeder (consumes samples, drives the FIFO write port)
//   slave  - the surrounding filter/FIFO side
interface dac_fifo_feeder_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DAC_W = 16
) ();

  logic             s_valid;
  logic [DW-1:0]    s_data;
  logic             fifo_full;
  logic             dacfifo_write;
  logic [DAC_W-1:0] dacfifo_wdata;

  modport master (
    input  s_valid,
    input  s_data,
    input  fifo_full,
    output dacfifo_write,
    output dacfifo_wdata
  );

  modport slave (
    output s_valid,
    output s_data,
    output fifo_full,
    input  dacfifo_write,
    input  dacfifo_wdata
  );

endinterface

// File: rtl/sat_shift.sv
// Combinational sample scaler: arithmetic right shift, saturate to DAC_W,
// optional MSB inversion (two's complement to offset-binary).
// Ports:
//   data_i       - signed input sample
//   shift_i      - arithmetic right-shift amount
//   offset_bin_i - 1 = invert MSB of the result
//   word_o       - scaled, saturated DAC word
module sat_shift #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DAC_W = 16
) (
  input  logic [DW-1:0]    data_i,
  input  logic [4:0]       shift_i,
  input  logic             offset_bin_i,
  output logic [DAC_W-1:0] word_o
);

  logic signed [DW-1:0]  shifted;
  logic [DW-DAC_W:0]     upper;
  logic                  pos_ovf;
  logic                  neg_ovf;

  assign shifted = $signed(data_i) >>> shift_i;
  // Value fits in DAC_W bits iff all bits from the DAC sign bit upward agree.
  assign upper   = shifted[DW-1:DAC_W-1];
  assign pos_ovf = ~shifted[DW-1] & (|upper);
  assign neg_ovf = shifted[DW-1] & ~(&upper);

  always_comb begin
    word_o = shifted[DAC_W-1:0];
    if (pos_ovf) begin
      word_o = {1'b0, {(DAC_W-1){1'b1}}};
    end else if (neg_ovf) begin
      word_o = {1'b1, {(DAC_W-1){1'b0}}};
    end
    if (offset_bin_i) begin
      word_o[DAC_W-1] = ~word_o[DAC_W-1];
    end
  end

endmodule

// File: rtl/dac_fifo_feeder.sv
// Moves filter output samples into the DAC FIFO: decimate, scale/saturate,
// one-entry hold buffer against FIFO backpressure, drop counting.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   enable      - 1 = run, 0 = drain pending sample then idle
//   decim       - keep 1 of every decim+1 samples (latched in idle)
//   shift       - arithmetic right shift before saturation (latched in idle)
//   offset_bin  - invert output MSB, applied when a sample is loaded
//   clear       - pulse: zero drop_cnt and ovf
//   bus         - sample input and FIFO write port
//   busy        - not idle
//   ovf         - sticky drop flag
//   drop_cnt    - saturating dropped-sample count
module dac_fifo_feeder
  import dac_feed_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned DAC_W   = DacWDef,
  parameter int unsigned DECIM_W = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [DECIM_W-1:0]  decim,
  input  logic [4:0]          shift,
  input  logic                offset_bin,
  input  logic                clear,
  dac_fifo_feeder_if.master   bus,
  output logic                busy,
  output logic                ovf,
  output logic [CNT_W-1:0]    drop_cnt
);

  state_e             state_q;
  logic [DECIM_W-1:0] decim_q;
  logic [4:0]         shift_q;
  logic [DECIM_W-1:0] dcnt_q;
  logic               hold_v_q;
  logic [DAC_W-1:0]   hold_d_q;
  logic               wr_q;
  logic [DAC_W-1:0]   wdata_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   drop_cnt_q;

  logic               keep;
  logic               drain;
  logic               load;
  logic               drop;
  logic [DAC_W-1:0]   sat_word;

  sat_shift #(
    .DW    (DW),
    .DAC_W (DAC_W)
  ) u_sat_shift (
    .data_i       (bus.s_data),
    .shift_i      (shift_q),
    .offset_bin_i (offset_bin),
    .word_o       (sat_word)
  );

  always_comb begin
    keep  = (state_q == StRun) & bus.s_valid & (dcnt_q == '0);
    drain = hold_v_q & ~bus.fifo_full;
    // Hold can take a new sample if empty or emptying on this same edge.
    load  = keep & (~hold_v_q | drain);
    drop  = keep & hold_v_q & bus.fifo_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      decim_q    <= '0;
      shift_q    <= '0;
      dcnt_q     <= '0;
      hold_v_q   <= 1'b0;
      hold_d_q   <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_q <= drain;
      if (drain) begin
        wdata_q <= hold_d_q;
      end

      if (load) begin
        hold_v_q <= 1'b1;
        hold_d_q <= sat_word;
      end else if (drain) begin
        hold_v_q <= 1'b0;
      end

      // clear takes priority over a coincident drop.
      if (clear) begin
        drop_cnt_q <= '0;
        ovf_q      <= 1'b0;
      end else if (drop) begin
        ovf_q <= 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
      end

      case (state_q)
        StIdle: begin
          decim_q <= decim;
          shift_q <= shift;
          if (enable) begin
            state_q <= StRun;
            dcnt_q  <= '0;
          end
        end
        StRun: begin
          if (bus.s_valid) begin
            dcnt_q <= (dcnt_q == decim_q) ? '0 : dcnt_q + DECIM_W'(1);
          end
          if (!enable) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!hold_v_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.dacfifo_write = wr_q;
  assign bus.dacfifo_wdata = wdata_q;
  assign busy              = (state_q != StIdle);
  assign ovf               = ovf_q;
  assign drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_dac_fifo_feeder.sv
module tb_dac_fifo_feeder;
  import dac_feed_pkg::*;

  localparam int unsigned DW      = 32;
  localparam int unsigned DAC_W   = 16;
  localparam int unsigned DECIM_W = 8;
  localparam int unsigned CNT_W   = 16;

  logic               clk        = 1'b0;
  logic               rst_n      = 1'b0;
  logic               enable     = 1'b0;
  logic [DECIM_W-1:0] decim      = '0;
  logic [4:0]         shift      = '0;
  logic               offset_bin = 1'b0;
  logic               clear      = 1'b0;
  logic               busy;
  logic               ovf;
  logic [CNT_W-1:0]   drop_cnt;

  int errors = 0;
  int checks = 0;

  dac_fifo_feeder_if #(.DW(DW), .DAC_W(DAC_W)) bus ();

  dac_fifo_feeder #(
    .DW      (DW),
    .DAC_W   (DAC_W),
    .DECIM_W (DECIM_W),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .decim      (decim),
    .shift      (shift),
    .offset_bin (offset_bin),
    .clear      (clear),
    .bus        (bus),
    .busy       (busy),
    .ovf        (ovf),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_mode   = 0;  // 0 idle, 1 run, 2 drain
  longint      m_idx    = 0;  // samples seen since entering run
  int          m_decim  = 0;
  int          m_shift  = 0;
  bit          m_hold_v = 0;
  logic [15:0] m_hold_d = '0;
  int          m_drops  = 0;
  bit          m_ovf    = 0;
  bit          m_hv0;
  bit          m_drop;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  function automatic logic [15:0] ref_scale(input logic [31:0] s, input int sh, input bit ob);
    longint      t;
    logic [15:0] r;
    t = longint'($signed(s));
    t = t >>> sh;
    if (t > 32767)       r = SAT_MAX;
    else if (t < -32768) r = SAT_MIN;
    else                 r = t[15:0];
    if (ob) r[15] = ~r[15];
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_idx = 0; m_decim = 0; m_shift = 0;
        m_hold_v = 0; m_hold_d = '0; m_drops = 0; m_ovf = 0;
      end else begin
        m_hv0  = m_hold_v;
        m_drop = 0;
        if (m_hold_v && !bus.fifo_full) begin
          exp_q.push_back(m_hold_d);
          m_hold_v = 0;
        end
        case (m_mode)
          0: begin
            m_decim = int'(decim);
            m_shift = int'(shift);
            if (enable) begin m_mode = 1; m_idx = 0; end
          end
          1: begin
            if (bus.s_valid) begin
              if (m_idx % (m_decim + 1) == 0) begin
                if (!m_hold_v) begin
                  m_hold_v = 1;
                  m_hold_d = ref_scale(bus.s_data, m_shift, offset_bin);
                end else begin
                  m_drop = 1;
                end
              end
              m_idx++;
            end
            if (!enable) m_mode = 2;
          end
          default: if (!m_hv0) m_mode = 0;
        endcase
        if (clear) begin
          m_drops = 0; m_ovf = 0;
        end else if (m_drop) begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
  end

  // Observed FIFO writes.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.dacfifo_write === 1'b1) got_q.push_back(bus.dacfifo_wdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int d, input int sh);
    decim  = DECIM_W'(d);
    shift  = 5'(sh);
    enable = 1'b1;
    cyc();
  endtask

  task automatic wait_idle();
    enable        = 1'b0;
    bus.s_valid   = 1'b0;
    bus.fifo_full = 1'b0;
    clear         = 1'b0;
    for (int i = 0; i < 40 && busy; i++) cyc();
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks += 5;
    if (bus.dacfifo_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b want 0", bus.dacfifo_write); end
    if (bus.dacfifo_wdata !== '0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.dacfifo_wdata); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    if (drop_cnt !== '0) begin errors++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    got_q.delete(); exp_q.delete();
    offset_bin = 1'b0;
    start(0, 0);
    for (int i = 0; i < 10; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'(i);
      cyc();
      if (i == 0) begin
        checks++;
        if (bus.dacfifo_write !== 1'b0) begin errors++; $display("FAIL basic_lat1: write=%b want 0", bus.dacfifo_write); end
      end
      if (i == 1) begin
        checks++;
        if (bus.dacfifo_write !== 1'b1 || bus.dacfifo_wdata !== 16'h0)
          begin errors++; $display("FAIL basic_lat2: write=%b data=%h want 1/0000", bus.dacfifo_write, bus.dacfifo_wdata); end
      end
    end
    wait_idle();
    checks++;
    if (got_q.size() != 10) begin errors++; $display("FAIL basic_count: got %0d want 10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      checks++;
      if (got_q[i] !== 16'(i)) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, got_q[i], 16'(i)); end
    end
  endtask

  task automatic test_decim();
    logic [15:0] want[4] = '{16'd0, 16'd4, 16'd8, 16'd12};
    got_q.delete(); exp_q.delete();
    start(3, 0);
    for (int i = 0; i < 16; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'(i);
      cyc();
    end
    wait_idle();
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL decim_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i] !== want[i]) begin errors++; $display("FAIL decim_data[%0d]: got %h want %h", i, got_q[i], want[i]); end
    end
  endtask

  task automatic test_saturate();
    logic [31:0] smp[3]   = '{32'h0007FFF0, 32'h00100000, 32'hFFF00000};
    logic [15:0] want0[3] = '{16'h7FFF, 16'h7FFF, 16'h8000};
    logic [15:0] want1[3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
    for (int ob = 0; ob < 2; ob++) begin
      got_q.delete(); exp_q.delete();
      offset_bin = ob[0];
      start(0, 4);
      for (int i = 0; i < 3; i++) begin
        bus.s_valid = 1'b1;
        bus.s_data  = smp[i];
        cyc();
      end
      wait_idle();
      checks++;
      if (got_q.size() != 3) begin errors++; $display("FAIL sat_count ob=%0d: got %0d want 3", ob, got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
        checks++;
        if (got_q[i] !== (ob == 1 ? want1[i] : want0[i]))
          begin errors++; $display("FAIL sat_data ob=%0d [%0d]: got %h want %h", ob, i, got_q[i], (ob == 1 ? want1[i] : want0[i])); end
      end
    end
    offset_bin = 1'b0;
  endtask

  task automatic test_overflow();
    got_q.delete(); exp_q.delete();
    start(0, 0);
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'(100 + i);
      cyc();
    end
    bus.s_valid   = 1'b0;
    bus.fifo_full = 1'b0;
    wait_idle();
    checks += 4;
    if (drop_cnt !== 16'd4) begin errors++; $display("FAIL ovf_drop_cnt: got %0d want 4", drop_cnt); end
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    if (got_q.size() != 1) begin errors++; $display("FAIL ovf_count: got %0d want 1", got_q.size()); end
    else if (got_q[0] !== 16'd100) begin errors++; $display("FAIL ovf_data: got %h want 0064", got_q[0]); end
    clear = 1'b1; cyc(); clear = 1'b0;
    checks++;
    if (drop_cnt !== '0 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: cnt=%0d ovf=%b want 0/0", drop_cnt, ovf); end

    // clear coincident with a drop: clear wins, next drop counts from zero
    start(0, 0);
    bus.fifo_full = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 32'd1; cyc();
    clear = 1'b1; bus.s_data = 32'd2; cyc(); clear = 1'b0;
    checks++;
    if (drop_cnt !== '0 || ovf !== 1'b0) begin errors++; $display("FAIL clear_vs_drop: cnt=%0d ovf=%b want 0/0", drop_cnt, ovf); end
    bus.s_data = 32'd3; cyc();
    checks++;
    if (drop_cnt !== 16'd1 || ovf !== 1'b1) begin errors++; $display("FAIL drop_after_clear: cnt=%0d ovf=%b want 1/1", drop_cnt, ovf); end
    wait_idle();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic test_drain();
    got_q.delete(); exp_q.delete();
    start(0, 0);
    bus.fifo_full = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 32'd55; cyc();
    bus.s_valid = 1'b0;
    enable = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1; bus.s_data = 32'd66;
      cyc();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy[%0d]: got %b want 1", i, busy); end
    end
    bus.s_valid   = 1'b0;
    bus.fifo_full = 1'b0;
    cyc();
    checks++;
    if (bus.dacfifo_write !== 1'b1 || bus.dacfifo_wdata !== 16'd55)
      begin errors++; $display("FAIL drain_write: write=%b data=%h want 1/0037", bus.dacfifo_write, bus.dacfifo_wdata); end
    cyc();
    checks += 4;
    if (bus.dacfifo_write !== 1'b0) begin errors++; $display("FAIL drain_extra_write: got %b want 0", bus.dacfifo_write); end
    if (busy !== 1'b0) begin errors++; $display("FAIL drain_idle: busy=%b want 0", busy); end
    if (got_q.size() != 1) begin errors++; $display("FAIL drain_count: got %0d want 1", got_q.size()); end
    if (drop_cnt !== '0) begin errors++; $display("FAIL drain_no_drop: cnt=%0d want 0", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    got_q.delete(); exp_q.delete();
    start(0, 0);
    bus.fifo_full = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 32'd77; cyc();
    bus.s_data = 32'd78; cyc();
    bus.s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.dacfifo_write !== 1'b0) begin errors++; $display("FAIL rstmid_write: got %b want 0", bus.dacfifo_write); end
    if (drop_cnt !== '0) begin errors++; $display("FAIL rstmid_drop_cnt: got %0d want 0", drop_cnt); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b want 0", ovf); end
    bus.fifo_full = 1'b0;
    enable = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (5) cyc();
    checks += 2;
    if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_no_write: got %0d writes want 0", got_q.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: busy=%b want 0", busy); end
    start(0, 0);
    bus.s_valid = 1'b1; bus.s_data = 32'd88; cyc();
    bus.s_valid = 1'b0;
    wait_idle();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'd88)
      begin errors++; $display("FAIL rstmid_resume: count=%0d first=%h want 1/0058", got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      got_q.delete(); exp_q.delete();
      start($urandom_range(0, 3), $urandom_range(0, 20));
      for (int i = 0; i < 300; i++) begin
        bus.s_valid   = ($urandom_range(0, 3) != 0);
        bus.s_data    = $urandom;
        bus.fifo_full = ($urandom_range(0, 2) == 0);
        offset_bin    = 1'($urandom_range(0, 1));
        clear         = ($urandom_range(0, 39) == 0);
        cyc();
      end
      wait_idle();
      checks += 3;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count r=%0d: got %0d want %0d", r, got_q.size(), exp_q.size()); end
      if (drop_cnt !== 16'(m_drops)) begin errors++; $display("FAIL rand_drop_cnt r=%0d: got %0d want %0d", r, drop_cnt, m_drops); end
      if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf r=%0d: got %b want %b", r, ovf, m_ovf); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data r=%0d [%0d]: got %h want %h", r, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.fifo_full = 1'b0;
    test_reset();
    test_basic();
    test_decim();
    test_saturate();
    test_overflow();
    test_drain();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
